// File: rtl/bist_pkg.sv
// Shared definitions for the March C- BIST sequencer: FSM states and per-element
// march tables (direction, op count, read-expect and write values).
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CMP  = 2'd2,
        ST_DONE = 2'd3
    } bist_state_t;

    localparam int unsigned MARCH_NUM_ELEM  = 6;
    localparam logic [2:0]  MARCH_LAST_ELEM = 3'(MARCH_NUM_ELEM - 1);

    // Bit e of each table describes march element e (M0..M5)
    localparam logic [7:0] ELEM_DOWN    = 8'b0011_1000;
    localparam logic [7:0] ELEM_TWO_OPS = 8'b0001_1110;
    localparam logic [7:0] READ_EXPECT  = 8'b0001_0100;
    localparam logic [7:0] WRITE_VALUE  = 8'b0000_1010;

    function automatic logic [1:0] elem_op_count(input logic [2:0] elem);
        return ELEM_TWO_OPS[elem] ? 2'd2 : 2'd1;
    endfunction

    // Two-op elements read first; M0 only writes, M5 only reads
    function automatic logic op_is_read(input logic [2:0] elem, input logic op_idx);
        if (ELEM_TWO_OPS[elem]) begin
            return !op_idx;
        end
        return elem == MARCH_LAST_ELEM;
    endfunction

    function automatic logic op_value(input logic [2:0] elem, input logic op_idx);
        return op_is_read(elem, op_idx) ? READ_EXPECT[elem] : WRITE_VALUE[elem];
    endfunction

    function automatic logic op_is_last(input logic [2:0] elem, input logic op_idx);
        return {1'b0, op_idx} == (elem_op_count(elem) - 2'd1);
    endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// Address walker for one march element: loads 0 or N-1, steps up or down,
// and flags the final address of the current direction.
module bist_addr_gen #(
    parameter int ADDR_W = 4
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic              load,
    input  logic              load_down,
    input  logic              step,
    input  logic              down,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_down ? '1 : '0;
        end else if (step) begin
            addr <= down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
        end
    end

    assign last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/march_bist_ctrl.sv
// March C- BIST sequencer: walks six march elements over the RAM, compares each
// read one cycle later and latches the first failing address and element.
module march_bist_ctrl
    import bist_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic              start,
    input  logic              tick_en,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_re,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem
);

    bist_state_t       state;
    logic [2:0]        elem;
    logic              op_idx;
    logic [ADDR_W-1:0] addr;
    logic              addr_last;
    logic              cur_read, cur_val, last_op;
    logic              issue, rd_match, advance, elem_end, start_ok;
    logic              ag_load, ag_load_down, ag_step;

    always_comb begin
        cur_read     = op_is_read(elem, op_idx);
        cur_val      = op_value(elem, op_idx);
        last_op      = op_is_last(elem, op_idx);
        issue        = (state == ST_RUN) && tick_en;
        rd_match     = (ram_rdata == {DATA_W{cur_val}});
        // Writes advance on issue; reads advance only after a matching compare
        advance      = (issue && !cur_read) || ((state == ST_CMP) && rd_match);
        elem_end     = advance && last_op && addr_last;
        start_ok     = start && ((state == ST_IDLE) || (state == ST_DONE));
        ag_load      = start_ok || (elem_end && (elem != MARCH_LAST_ELEM));
        ag_load_down = !start_ok && ELEM_DOWN[elem + 3'd1];
        ag_step      = advance && last_op && !addr_last;
    end

    bist_addr_gen #(
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .down      (ELEM_DOWN[elem]),
        .addr      (addr),
        .last      (addr_last)
    );

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            elem      <= '0;
            op_idx    <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
        end else begin
            if (advance) begin
                op_idx <= !last_op;
                if (elem_end && (elem != MARCH_LAST_ELEM)) begin
                    elem <= elem + 3'd1;
                end
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_RUN;
                        elem      <= '0;
                        op_idx    <= 1'b0;
                        fail      <= 1'b0;
                        fail_addr <= '0;
                        fail_elem <= '0;
                    end
                end
                ST_RUN: begin
                    if (issue && cur_read) begin
                        state <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (!rd_match) begin
                        state     <= ST_DONE;
                        fail      <= 1'b1;
                        fail_addr <= addr;
                        fail_elem <= elem;
                    end else if (elem_end && (elem == MARCH_LAST_ELEM)) begin
                        state <= ST_DONE;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ram_addr  = addr;
    assign ram_re    = issue && cur_read;
    assign ram_we    = issue && !cur_read;
    assign ram_wdata = (state == ST_RUN) ? {DATA_W{cur_val}} : '0;
    assign busy      = (state == ST_RUN) || (state == ST_CMP);
    assign done      = (state == ST_DONE);

endmodule
